// File: rtl/registro_fifo.sv
// rtl/registro_fifo.sv - N-bit x DEPTH register queue with push/pop handshake, occupancy count and error flags
//
// Purpose: buffers words in order between a producer and a consumer in the same
// clock domain. Storage is a register array addressed by wrap-around pointers;
// the popped word is held on a registered output until the next accepted pop.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        asynchronous active-low reset
//   clear_i      synchronous flush, wins over push/pop
//   push_i       write request, data_i captured when accepted
//   data_i       write data (N bits)
//   pop_i        read request
//   data_o       last popped word (registered)
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//   count_o      current occupancy, 0..DEPTH
//   overflow_o   one-cycle pulse per rejected push
//   underflow_o  one-cycle pulse per rejected pop
module registro_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [N-1:0]             data_i,
  input  logic                     pop_i,
  output logic [N-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_o == DEPTH_C);
  assign empty_o = (count_o == '0);

  // A full queue still accepts a push when a pop frees the slot the same edge.
  // On an empty queue the pop is rejected even if a push arrives, so the new
  // word is never bypassed to data_o.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    push_ok = push_i && (!full_o || pop_i);
    pop_ok  = pop_i && !empty_o;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      data_o      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        // When full with push+pop, wr_ptr == rd_ptr: this reads the old word
        // while the storage block overwrites it on the same edge.
        data_o <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
      overflow_o  <= push_i && !push_ok;
      underflow_o <= pop_i && !pop_ok;
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (rst_i && !clear_i && push_ok) begin
      mem[wr_ptr] <= data_i;
    end
  end

endmodule
